// File: rtl/cgra_im_loader.sv
// Configuration-stream loader feeding the CGRA instruction-memory write port.
// Parses header/payload beats into one-hot single-cycle writes to the decoder
// IMs and the immediate IMs. Immediate instructions are assembled from two beats.
module cgra_im_loader #(
  parameter int unsigned D_WIDTH           = 32,
  parameter int unsigned I_WIDTH           = 12,
  parameter int unsigned I_IMM_WIDTH       = 33,
  parameter int unsigned IM_MEM_ADDR_WIDTH = 8,
  parameter int unsigned NUM_ID            = 10,
  parameter int unsigned NUM_IMM           = 3
) (
  input  logic                          iClk,
  input  logic                          iReset_n,
  input  logic                          iCfg_Valid,
  input  logic [D_WIDTH-1:0]            iCfg_Data,
  output logic                          oCfg_Ready,
  input  logic                          iErrClear,
  output logic [NUM_ID+NUM_IMM-1:0]     oIM_WriteEnable,
  output logic [IM_MEM_ADDR_WIDTH-1:0]  oIM_WriteAddress,
  output logic [I_WIDTH-1:0]            oIM_WriteData,
  output logic [I_IMM_WIDTH-1:0]        oIM_WriteData_IMM,
  output logic                          oBusy,
  output logic                          oDone,
  output logic                          oError
);

  localparam int unsigned NUM_IM    = NUM_ID + NUM_IMM;
  localparam int unsigned CNT_WIDTH = 16;
  localparam int unsigned TGT_WIDTH = 8;
  localparam int unsigned HI_WIDTH  = I_IMM_WIDTH - D_WIDTH;

  localparam logic [TGT_WIDTH-1:0] NUM_IM_T = TGT_WIDTH'(NUM_IM);
  localparam logic [TGT_WIDTH-1:0] NUM_ID_T = TGT_WIDTH'(NUM_ID);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LO    = 3'd1,
    HI    = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } loaderState_t;

  loaderState_t                 state, stateNext;
  logic [CNT_WIDTH-1:0]         cntReg, cntNext;
  logic [IM_MEM_ADDR_WIDTH-1:0] addrReg, addrNext;
  logic [TGT_WIDTH-1:0]         tgtReg, tgtNext;
  logic [D_WIDTH-1:0]           loWord, loWordNext;

  logic [NUM_IM-1:0]            weNext;
  logic [IM_MEM_ADDR_WIDTH-1:0] waNext;
  logic [I_WIDTH-1:0]           wdNext;
  logic [I_IMM_WIDTH-1:0]       wdImmNext;
  logic                         doneNext;
  logic                         errSet;
  logic                         errNext;

  // Header field decode
  logic [TGT_WIDTH-1:0]         hdrTarget;
  logic [CNT_WIDTH-1:0]         hdrCount;
  logic [IM_MEM_ADDR_WIDTH-1:0] hdrAddr;
  logic                         hdrBad;
  logic                         beatAccept;
  logic                         lastBeat;
  logic                         tgtIsImm;

  assign hdrTarget  = iCfg_Data[7:0];
  assign hdrCount   = iCfg_Data[23:8];
  assign hdrAddr    = IM_MEM_ADDR_WIDTH'(iCfg_Data[31:24]);
  assign hdrBad     = (hdrTarget >= NUM_IM_T);
  assign beatAccept = iCfg_Valid && oCfg_Ready;
  assign lastBeat   = (cntReg == CNT_WIDTH'(1));
  assign tgtIsImm   = (tgtReg >= NUM_ID_T);

  // Ready and busy decode the state register directly
  assign oCfg_Ready = (state != DONE);
  assign oBusy      = (state != IDLE);

  // Next-state, counters and next values of the registered outputs
  always_comb begin
    stateNext  = state;
    cntNext    = cntReg;
    addrNext   = addrReg;
    tgtNext    = tgtReg;
    loWordNext = loWord;
    weNext     = '0;
    waNext     = oIM_WriteAddress;
    wdNext     = '0;
    wdImmNext  = '0;
    errSet     = 1'b0;

    unique case (state)
      IDLE: begin
        if (beatAccept) begin
          tgtNext  = hdrTarget;
          cntNext  = hdrCount;
          addrNext = hdrAddr;
          errSet   = hdrBad;
          if (hdrCount == '0) begin
            stateNext = DONE;
          end else if (hdrBad) begin
            stateNext = DRAIN;
          end else begin
            stateNext = LO;
          end
        end
      end

      LO: begin
        if (beatAccept) begin
          if (tgtIsImm) begin
            loWordNext = iCfg_Data;
            stateNext  = HI;
          end else begin
            weNext    = NUM_IM'(1) << tgtReg;
            waNext    = addrReg;
            wdNext    = iCfg_Data[I_WIDTH-1:0];
            addrNext  = addrReg + IM_MEM_ADDR_WIDTH'(1);
            cntNext   = cntReg - CNT_WIDTH'(1);
            stateNext = lastBeat ? DONE : LO;
          end
        end
      end

      HI: begin
        if (beatAccept) begin
          weNext    = NUM_IM'(1) << tgtReg;
          waNext    = addrReg;
          wdImmNext = {iCfg_Data[HI_WIDTH-1:0], loWord};
          addrNext  = addrReg + IM_MEM_ADDR_WIDTH'(1);
          cntNext   = cntReg - CNT_WIDTH'(1);
          stateNext = lastBeat ? DONE : LO;
        end
      end

      DRAIN: begin
        if (beatAccept) begin
          cntNext   = cntReg - CNT_WIDTH'(1);
          stateNext = lastBeat ? DONE : DRAIN;
        end
      end

      DONE: begin
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Done pulse coincides with the DONE state; a new error set beats a clear
  assign doneNext = (stateNext == DONE);
  assign errNext  = errSet ? 1'b1 : (iErrClear ? 1'b0 : oError);

  // State, transfer bookkeeping and registered outputs
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state             <= IDLE;
      cntReg            <= '0;
      addrReg           <= '0;
      tgtReg            <= '0;
      loWord            <= '0;
      oIM_WriteEnable   <= '0;
      oIM_WriteAddress  <= '0;
      oIM_WriteData     <= '0;
      oIM_WriteData_IMM <= '0;
      oDone             <= 1'b0;
      oError            <= 1'b0;
    end else begin
      state             <= stateNext;
      cntReg            <= cntNext;
      addrReg           <= addrNext;
      tgtReg            <= tgtNext;
      loWord            <= loWordNext;
      oIM_WriteEnable   <= weNext;
      oIM_WriteAddress  <= waNext;
      oIM_WriteData     <= wdNext;
      oIM_WriteData_IMM <= wdImmNext;
      oDone             <= doneNext;
      oError            <= errNext;
    end
  end

endmodule

// File: tb/tb_cgra_im_loader.sv
// Directed self-checking bench for cgra_im_loader.
module tb_cgra_im_loader;

  localparam int unsigned D_WIDTH           = 32;
  localparam int unsigned I_WIDTH           = 12;
  localparam int unsigned I_IMM_WIDTH       = 33;
  localparam int unsigned IM_MEM_ADDR_WIDTH = 8;
  localparam int unsigned NUM_ID            = 10;
  localparam int unsigned NUM_IMM           = 3;

  logic                          iClk;
  logic                          iReset_n;
  logic                          iCfg_Valid;
  logic [D_WIDTH-1:0]            iCfg_Data;
  logic                          oCfg_Ready;
  logic                          iErrClear;
  logic [NUM_ID+NUM_IMM-1:0]     oIM_WriteEnable;
  logic [IM_MEM_ADDR_WIDTH-1:0]  oIM_WriteAddress;
  logic [I_WIDTH-1:0]            oIM_WriteData;
  logic [I_IMM_WIDTH-1:0]        oIM_WriteData_IMM;
  logic                          oBusy;
  logic                          oDone;
  logic                          oError;

  int checks   = 0;
  int failures = 0;

  cgra_im_loader #(
    .D_WIDTH(D_WIDTH), .I_WIDTH(I_WIDTH), .I_IMM_WIDTH(I_IMM_WIDTH),
    .IM_MEM_ADDR_WIDTH(IM_MEM_ADDR_WIDTH), .NUM_ID(NUM_ID), .NUM_IMM(NUM_IMM)
  ) dut (
    .iClk(iClk), .iReset_n(iReset_n),
    .iCfg_Valid(iCfg_Valid), .iCfg_Data(iCfg_Data), .oCfg_Ready(oCfg_Ready),
    .iErrClear(iErrClear),
    .oIM_WriteEnable(oIM_WriteEnable), .oIM_WriteAddress(oIM_WriteAddress),
    .oIM_WriteData(oIM_WriteData), .oIM_WriteData_IMM(oIM_WriteData_IMM),
    .oBusy(oBusy), .oDone(oDone), .oError(oError)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are looked at 1 time unit after the edge
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic sendBeat(input logic [D_WIDTH-1:0] d);
    iCfg_Valid = 1'b1;
    iCfg_Data  = d;
    tick();
  endtask

  task automatic idle();
    iCfg_Valid = 1'b0;
    iCfg_Data  = '0;
    tick();
  endtask

  // Check one write cycle: enable, address and both data buses
  task automatic chkWrite(input string tag, input logic [12:0] we, input logic [7:0] wa,
                          input logic [11:0] wd, input logic [32:0] wdi);
    chk({tag, "_we"},   64'(oIM_WriteEnable),   64'(we));
    chk({tag, "_addr"}, 64'(oIM_WriteAddress),  64'(wa));
    chk({tag, "_data"}, 64'(oIM_WriteData),     64'(wd));
    chk({tag, "_imm"},  64'(oIM_WriteData_IMM), 64'(wdi));
  endtask

  initial begin
    iReset_n   = 1'b0;
    iCfg_Valid = 1'b0;
    iCfg_Data  = '0;
    iErrClear  = 1'b0;
    tick();
    tick();
    chkWrite("rst", 13'h0, 8'h00, 12'h000, 33'h0);
    chk("rst_done",  64'(oDone),  64'd0);
    chk("rst_err",   64'(oError), 64'd0);
    chk("rst_busy",  64'(oBusy),  64'd0);
    iReset_n = 1'b1;
    tick();
    chk("rst_ready", 64'(oCfg_Ready), 64'd1);

    // Reset in the middle of an immediate load: half-assembled word is lost
    sendBeat(32'h20_0001_0B);
    chk("mid_busy", 64'(oBusy), 64'd1);
    sendBeat(32'h1234_5678);
    chk("mid_lo_nowe", 64'(oIM_WriteEnable), 64'd0);
    iCfg_Valid = 1'b0;
    #2;
    iReset_n = 1'b0;
    #1;
    chkWrite("mid_rst", 13'h0, 8'h00, 12'h000, 33'h0);
    chk("mid_rst_busy", 64'(oBusy), 64'd0);
    tick();
    chk("mid_rst_we_hold", 64'(oIM_WriteEnable), 64'd0);
    iReset_n = 1'b1;
    tick();
    sendBeat(32'h30_0001_0C);
    sendBeat(32'h1111_1111);
    chk("fresh_lo_nowe", 64'(oIM_WriteEnable), 64'd0);
    sendBeat(32'h0000_0000);
    chkWrite("fresh_imm", 13'h1000, 8'h30, 12'h000, 33'h0_1111_1111);
    chk("fresh_done", 64'(oDone), 64'd1);
    idle();

    // Decoder load, continuous valid
    sendBeat(32'h10_0003_02);
    chk("dec_hdr_we", 64'(oIM_WriteEnable), 64'd0);
    sendBeat(32'h0000_0ABC);
    chkWrite("dec_w0", 13'h0004, 8'h10, 12'hABC, 33'h0);
    chk("dec_w0_done", 64'(oDone), 64'd0);
    sendBeat(32'hFFFF_F123);
    chkWrite("dec_w1", 13'h0004, 8'h11, 12'h123, 33'h0);
    sendBeat(32'h0000_0FFF);
    chkWrite("dec_w2", 13'h0004, 8'h12, 12'hFFF, 33'h0);
    chk("dec_done",  64'(oDone),      64'd1);
    chk("dec_ready", 64'(oCfg_Ready), 64'd0);
    idle();
    chk("dec_idle_busy", 64'(oBusy), 64'd0);
    chk("dec_idle_done", 64'(oDone), 64'd0);
    chk("dec_idle_we",   64'(oIM_WriteEnable), 64'd0);

    // Immediate load with address wrap from 0xFF
    sendBeat(32'hFE_0002_0B);
    sendBeat(32'h89AB_CDEF);
    chk("imm_lo0_we", 64'(oIM_WriteEnable), 64'd0);
    sendBeat(32'h0000_0001);
    chkWrite("imm_w0", 13'h0800, 8'hFE, 12'h000, 33'h1_89AB_CDEF);
    chk("imm_w0_done", 64'(oDone), 64'd0);
    sendBeat(32'h0000_0005);
    chk("imm_lo1_we", 64'(oIM_WriteEnable), 64'd0);
    sendBeat(32'h0000_0000);
    chkWrite("imm_w1", 13'h0800, 8'hFF, 12'h000, 33'h0_0000_0005);
    chk("imm_done", 64'(oDone), 64'd1);
    idle();

    // Decoder address wrap
    sendBeat(32'hFF_0003_00);
    sendBeat(32'h0000_0001);
    chkWrite("wrap_w0", 13'h0001, 8'hFF, 12'h001, 33'h0);
    sendBeat(32'h0000_0002);
    chkWrite("wrap_w1", 13'h0001, 8'h00, 12'h002, 33'h0);
    sendBeat(32'h0000_0003);
    chkWrite("wrap_w2", 13'h0001, 8'h01, 12'h003, 33'h0);
    chk("wrap_done", 64'(oDone), 64'd1);
    idle();

    // Bad target: error, discard payload, then a good load still works
    sendBeat(32'h00_0002_0D);
    chk("bad_err",  64'(oError), 64'd1);
    chk("bad_busy", 64'(oBusy),  64'd1);
    sendBeat(32'h0000_0AAA);
    chk("bad_d0_we",   64'(oIM_WriteEnable), 64'd0);
    chk("bad_d0_done", 64'(oDone), 64'd0);
    sendBeat(32'h0000_0BBB);
    chk("bad_d1_we",   64'(oIM_WriteEnable), 64'd0);
    chk("bad_d1_done", 64'(oDone), 64'd1);
    idle();
    sendBeat(32'h40_0001_01);
    sendBeat(32'h0000_05A5);
    chkWrite("after_bad", 13'h0002, 8'h40, 12'h5A5, 33'h0);
    chk("after_bad_done", 64'(oDone),  64'd1);
    chk("after_bad_err",  64'(oError), 64'd1);
    idle();
    iErrClear = 1'b1;
    tick();
    iErrClear = 1'b0;
    chk("err_clear", 64'(oError), 64'd0);

    // Zero count
    sendBeat(32'h50_0000_03);
    chk("zero_done",  64'(oDone),           64'd1);
    chk("zero_we",    64'(oIM_WriteEnable), 64'd0);
    chk("zero_ready", 64'(oCfg_Ready),      64'd0);
    idle();
    chk("zero_idle_done", 64'(oDone), 64'd0);
    chk("zero_idle_busy", 64'(oBusy), 64'd0);

    // Valid gaps during a T=5 load
    sendBeat(32'h70_0003_05);
    idle();
    chk("gap0_we", 64'(oIM_WriteEnable), 64'd0);
    sendBeat(32'h0000_0111);
    chkWrite("gap_w0", 13'h0020, 8'h70, 12'h111, 33'h0);
    idle();
    chk("gap1_we",   64'(oIM_WriteEnable), 64'd0);
    chk("gap1_busy", 64'(oBusy), 64'd1);
    idle();
    sendBeat(32'h0000_0222);
    chkWrite("gap_w1", 13'h0020, 8'h71, 12'h222, 33'h0);
    chk("gap_w1_done", 64'(oDone), 64'd0);
    idle();
    chk("gap2_we", 64'(oIM_WriteEnable), 64'd0);
    sendBeat(32'h0000_0333);
    chkWrite("gap_w2", 13'h0020, 8'h72, 12'h333, 33'h0);
    chk("gap_done", 64'(oDone), 64'd1);
    idle();
    chk("end_busy", 64'(oBusy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cgra_im_loader.md
# cgra_im_loader

- Configuration-stream loader that sits directly upstream of the CGRA memory block's instruction-memory write port.
- Accepts a valid/ready word stream of headers and payload, and turns it into one-hot, single-cycle writes to the NUM_ID decoder instruction memories and the NUM_IMM immediate instruction memories.
- Assembles I_IMM_WIDTH-bit immediate instructions from two stream beats.
- Reports completion and bad-target errors.

## Interface
Parameters:
- D_WIDTH, 32: stream word width; must be ≥ 32 to hold the header.
- I_WIDTH, 12: decoder instruction width.
- I_IMM_WIDTH, 33: immediate instruction width; must satisfy D_WIDTH < I_IMM_WIDTH ≤ 2*D_WIDTH.
- IM_MEM_ADDR_WIDTH, 8: instruction memory address width.
- NUM_ID, 10: number of decoder IMs, at targets 0..NUM_ID-1.
- NUM_IMM, 3: number of immediate IMs, at targets NUM_ID..NUM_ID+NUM_IMM-1.

Ports:
- iClk, in, 1: clock. One clock; reset is asynchronous and active-low.
- iReset_n, in, 1: asynchronous active-low reset.
- iCfg_Valid, in, 1: stream word valid.
- iCfg_Data, in, D_WIDTH: stream word.
- oCfg_Ready, out, 1: loader accepts the word this cycle.
- iErrClear, in, 1: synchronous clear of oError.
- oIM_WriteEnable, out, NUM_ID+NUM_IMM: one-hot write strobe.
- oIM_WriteAddress, out, IM_MEM_ADDR_WIDTH: shared write address.
- oIM_WriteData, out, I_WIDTH: decoder write data.
- oIM_WriteData_IMM, out, I_IMM_WIDTH: immediate write data.
- oBusy, out, 1: a transfer is in progress (state ≠ IDLE).
- oDone, out, 1: one-cycle pulse at the end of a transfer.
- oError, out, 1: sticky bad-target flag.

## Operation
- A beat is accepted when iCfg_Valid && oCfg_Ready.
- Header beat fields:
  - [7:0]: target index T.
  - [23:8]: instruction count N.
  - [31:24]: start address A. Only the low IM_MEM_ADDR_WIDTH bits are used.
- States:
  - IDLE: accepts a header.
    - N = 0 → DONE.
    - T ≥ NUM_ID+NUM_IMM → set oError, go to DRAIN with N beats to discard.
    - Otherwise → LO.
  - LO: accepts one payload beat.
    - Decoder target: issue a write with data = beat[I_WIDTH-1:0]; upper bits are ignored. Decrement N. Go to DONE when N reaches 0, else stay in LO.
    - Immediate target: latch the beat into the low D_WIDTH bits, go to HI.
  - HI (immediate targets only): accepts a beat.
    - Issue a write with data = {beat[I_IMM_WIDTH-D_WIDTH-1:0], latched low word}.
    - Decrement N. Go to DONE when N reaches 0, else return to LO.
  - DRAIN: accepts and discards beats, decrementing N. Go to DONE when N reaches 0. No writes are issued.
  - DONE: lasts one cycle. oDone = 1, then IDLE.
- Addressing:
  - The write address starts at A and increments by 1 after each issued write.
  - It wraps modulo 2^IM_MEM_ADDR_WIDTH (255 → 0).
- oCfg_Ready = 1 in IDLE, LO, HI and DRAIN; 0 in DONE.
- oError:
  - Set on a bad header.
  - Cleared by iErrClear when no set occurs in the same cycle; set wins.
  - Does not block later transfers.
- Write outputs:
  - oIM_WriteEnable = 1<<T for exactly one cycle per issued write, else 0.
  - On a decoder write, oIM_WriteData_IMM = 0. On an immediate write, oIM_WriteData = 0. Both data buses are 0 when there is no write.

## Timing
- All outputs are registered except oCfg_Ready and oBusy, which decode the state register.
- Reset (asynchronous, any time, including mid-transfer):
  - State → IDLE.
  - oIM_WriteEnable, oIM_WriteAddress, both data buses, oDone and oError → 0.
  - The partial transfer is lost; no write is issued for a half-assembled immediate.
- Latencies, for a beat accepted in cycle t:
  - The write it completes appears in cycle t+1.
  - A bad header sets oError in t+1.
- End of transfer, with the last payload beat accepted at t:
  - The final write and DONE (oDone = 1, oCfg_Ready = 0) both occur in t+1.
  - IDLE, ready for the next header, in t+2.
- A header with N = 0 accepted at t gives oDone at t+1.
- Throughput:
  - Decoder targets: one write per cycle under continuous valid.
  - Immediate targets: one write per two cycles.
- Valid low mid-transfer: the state holds and no write is issued.
- Counter width is 16 bits. N = 65535 is legal, and addresses wrap repeatedly.

## Test plan
- Reset mid-immediate load: assert iReset_n low after the LO beat → no write, all outputs 0. A fresh header then loads normally.
- Decoder load: header T=2, N=3, A=0x10, then payload 0xABC, 0x123, 0xFFF (continuous valid) →
  - Enable 0x0004 at 0x10/0x11/0x12 with data 0xABC/0x123/0xFFF on consecutive cycles.
  - oDone in the cycle of the third write.
- Immediate load: header T=11, N=2, A=0xFE, beats 0x89ABCDEF, 0x1, 0x00000005, 0x0 →
  - Enable bit 11 at 0xFE with data 0x189ABCDEF.
  - Enable bit 11 at 0xFF with data 0x000000005.
  - No write after an odd beat.
- Address wrap: T=0, N=3, A=0xFF → writes at 0xFF, 0x00, 0x01.
- Bad target: T=13, N=2, then two beats →
  - oError = 1 from t+1; no enables; oDone after the second beat.
  - A following valid header loads correctly.
  - iErrClear clears oError.
- Zero count and backpressure:
  - N = 0 → oDone one cycle later with no writes.
  - Gaps in iCfg_Valid during a T=5 load → writes only on accepted beats, addresses contiguous.
